// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: glyph codes, digit
// counts, the snapshot FSM state type and small helper functions.
package seg7_pkg;

  // Segment order is [0]=a .. [6]=g, active-high.
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_MINUS = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned BCD_DIGITS = 10;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} snap_state_e;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

  // Two's-complement magnitude in 32-bit unsigned; 0x80000000 maps to itself (2147483648).
  function automatic logic [31:0] magnitude(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle of the seven-segment scan driver.
//   value_i    : 32-bit word to display
//   mode_i     : 0 = hex, 1 = signed decimal
//   blank_lz_i : 1 = blank leading zeros
//   seg_o      : segments a..g in [6:0], dp in [7] (always 0)
//   an_o       : one-hot digit enable, [0] = rightmost digit
//   busy_o     : decimal conversion in progress
interface seg7_scan_driver_if;
  logic [31:0] value_i;
  logic        mode_i;
  logic        blank_lz_i;
  logic [7:0]  seg_o;
  logic [7:0]  an_o;
  logic        busy_o;

  modport master (
    output value_i, mode_i, blank_lz_i,
    input  seg_o, an_o, busy_o
  );

  modport slave (
    input  value_i, mode_i, blank_lz_i,
    output seg_o, an_o, busy_o
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: 32-bit binary to 10 BCD digits, one shift per cycle.
//   clk, rst : clock, asynchronous active-low reset
//   start_i  : load bin_i (the first shift happens on the load edge)
//   bin_i    : binary input
//   bcd_o    : 40-bit BCD result, digit k in [4k+3:4k]; valid when done_o
//   done_o   : one-cycle pulse after the 32nd shift
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] bin_i,
  output logic [39:0] bcd_o,
  output logic        done_o
);

  logic [31:0] bin_q, bin_d;
  logic [39:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic        done_q, done_d;

  // Add 3 to every digit >= 5, then shift the next binary bit in.
  function automatic logic [39:0] dabble_step(input logic [39:0] bcd, input logic in_bit);
    logic [39:0] r;
    r = bcd;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    r = {r[38:0], in_bit};
    return r;
  endfunction

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start_i) begin
      // BCD starts at zero, so iteration 1 needs no adjust and is folded into the load.
      bcd_d = {39'd0, bin_i[31]};
      bin_d = {bin_i[30:0], 1'b0};
      cnt_d = 5'd1;
      run_d = 1'b1;
    end else if (run_q) begin
      bcd_d = dabble_step(bcd_q, bin_q[31]);
      bin_d = {bin_q[30:0], 1'b0};
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = done_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment driver. Snapshots {mode, value, blank}
// whenever they change, optionally converts to signed decimal, then commits all
// eight glyphs to the display buffer in one cycle; the scanner reads only that
// buffer, so a partially updated value is never shown.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of seg7_scan_driver_if (value/mode/blank in, seg/an/busy out)
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned CNT_W    = 17
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_driver_if.slave   bus
);

  snap_state_e state_q, state_d;
  logic [31:0] cap_value_q, cap_value_d;
  logic        cap_mode_q, cap_mode_d;
  logic        cap_blank_q, cap_blank_d;
  logic        snap_valid_q, snap_valid_d;
  logic [NUM_DIGITS-1:0][6:0] buf_q, buf_d;

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       an_q, an_d;

  logic        conv_start;
  logic        conv_done;
  logic [39:0] bcd;

  // Converter loads on the same edge the FSM captures, so it reads the live input.
  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (conv_start),
    .bin_i   (magnitude(bus.value_i)),
    .bcd_o   (bcd),
    .done_o  (conv_done)
  );

  // Digit formation from the captured snapshot (consumed in COMMIT).
  logic [NUM_DIGITS-1:0][3:0] dig;
  logic [NUM_DIGITS-1:0][6:0] glyphs;
  logic                       neg;
  logic                       ovf;
  logic [2:0]                 msd;

  always_comb begin
    neg = cap_mode_q & cap_value_q[31];
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      dig[k] = cap_mode_q ? bcd[4*k +: 4] : cap_value_q[4*k +: 4];
    end
    // Positive: > 99_999_999 needs digit 8 or 9. Negative: > 9_999_999 also needs digit 7.
    ovf = cap_mode_q & ((|bcd[39:32]) | (neg & (|bcd[31:28])));
    msd = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (dig[k] != 4'd0) msd = 3'(k);
    end
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (ovf) begin
        glyphs[k] = GLYPH_MINUS;
      end else if (neg && ((bus.blank_lz_i && (3'(k) == msd + 3'd1)) ||
                           (!bus.blank_lz_i && (k == NUM_DIGITS - 1)))) begin
        // msd <= 6 for a non-overflowing negative, so msd+1 never wraps.
        glyphs[k] = GLYPH_MINUS;
      end else if (bus.blank_lz_i && (3'(k) > msd)) begin
        glyphs[k] = GLYPH_BLANK;
      end else begin
        glyphs[k] = hex_glyph(dig[k]);
      end
    end
  end

  // Snapshot FSM.
  always_comb begin
    state_d      = state_q;
    cap_value_d  = cap_value_q;
    cap_mode_d   = cap_mode_q;
    cap_blank_d  = cap_blank_q;
    snap_valid_d = snap_valid_q;
    buf_d        = buf_q;
    conv_start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!snap_valid_q || (bus.mode_i != cap_mode_q) || (bus.value_i != cap_value_q) ||
            (bus.blank_lz_i != cap_blank_q)) begin
          cap_value_d = bus.value_i;
          cap_mode_d  = bus.mode_i;
          conv_start  = bus.mode_i;
          state_d     = bus.mode_i ? CONV : COMMIT;
        end
      end
      CONV: begin
        if (conv_done) state_d = COMMIT;
      end
      COMMIT: begin
        // Record the blank setting actually used so a later change re-triggers.
        buf_d        = glyphs;
        cap_blank_d  = bus.blank_lz_i;
        snap_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan: outputs follow the next-state buffer and index so a commit coinciding
  // with an index advance shows the new digit from the new buffer.
  always_comb begin
    if (presc_q == CNT_W'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
    end else begin
      presc_d = presc_q + CNT_W'(1);
      idx_d   = idx_q;
    end
    seg_d = {1'b0, buf_d[idx_d]};
    an_d  = snap_valid_d ? (8'd1 << idx_d) : 8'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cap_value_q  <= '0;
      cap_mode_q   <= 1'b0;
      cap_blank_q  <= 1'b0;
      snap_valid_q <= 1'b0;
      buf_q        <= '0;
      presc_q      <= '0;
      idx_q        <= '0;
      seg_q        <= '0;
      an_q         <= '0;
    end else begin
      state_q      <= state_d;
      cap_value_q  <= cap_value_d;
      cap_mode_q   <= cap_mode_d;
      cap_blank_q  <= cap_blank_d;
      snap_valid_q <= snap_valid_d;
      buf_q        <= buf_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign bus.seg_o  = seg_q;
  assign bus.an_o   = an_q;
  assign bus.busy_o = (state_q == CONV);

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=4. Expected display frames
// (digit 7 in the top byte .. digit 0 in the bottom byte) are queued when the
// stimulus is driven and popped when a full scan frame has been collected.
module tb_seg7_scan_driver;

  localparam int unsigned SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_q [$];

  seg7_scan_driver_if bus_if ();

  seg7_scan_driver #(
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] v, input logic m, input logic b, input logic [63:0] e);
    @(negedge clk);
    bus_if.value_i    = v;
    bus_if.mode_i     = m;
    bus_if.blank_lz_i = b;
    exp_q.push_back(e);
  endtask

  // Counts edges while busy_o is high, bounded.
  task automatic wait_busy(output int n);
    n = 0;
    while (bus_if.busy_o === 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("busy_bound", 64'(n < 100), 64'd1);
  endtask

  // Watches one full scan rotation and compares it with the oldest queued frame.
  task automatic check_frame(input string tag);
    logic [63:0] got;
    logic [63:0] expv;
    logic [7:0]  seen;
    logic        an_bad;
    got    = '0;
    seen   = '0;
    an_bad = 1'b0;
    check({tag, "_sb"}, 64'(exp_q.size() != 0), 64'd1);
    expv = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    for (int i = 0; i < 8 * SCAN_DIV; i++) begin
      if (!$onehot(bus_if.an_o)) begin
        an_bad = 1'b1;
      end else begin
        for (int k = 0; k < 8; k++) begin
          if (bus_if.an_o[k]) begin
            got[8*k +: 8] = bus_if.seg_o;
            seen[k]       = 1'b1;
          end
        end
      end
      @(posedge clk);
      #1;
    end
    check({tag, "_an"}, 64'(an_bad), 64'd0);
    check({tag, "_seen"}, 64'(seen), 64'hFF);
    check(tag, got, expv);
  endtask

  task automatic apply(input string tag, input logic [31:0] v, input logic m, input logic b,
                       input logic [63:0] e);
    drive(v, m, b, e);
    wait_edges(m ? 34 : 2);
    check_frame(tag);
  endtask

  initial begin
    int          n;
    int          edges;
    logic [63:0] frame7;

    // Reset state; first snapshot is the hex word, committed after release.
    rst               = 1'b0;
    bus_if.value_i    = 32'h12AB_CDEF;
    bus_if.mode_i     = 1'b0;
    bus_if.blank_lz_i = 1'b0;
    exp_q.push_back(64'h065B_777C_395E_7971);
    wait_edges(3);
    check("rst_seg", 64'(bus_if.seg_o), 64'd0);
    check("rst_an", 64'(bus_if.an_o), 64'd0);
    check("rst_busy", 64'(bus_if.busy_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_edges(1);
    check("t1_an_pre", 64'(bus_if.an_o), 64'd0);
    wait_edges(1);
    check_frame("t1_hex");

    // Negative decimal with blanking; busy for exactly 32 cycles.
    drive(-32'sd1234, 1'b1, 1'b1, 64'h0000_0040_065B_4F66);
    wait_edges(1);
    check("t2_busy_start", 64'(bus_if.busy_o), 64'd1);
    wait_busy(n);
    check("t2_busy_len", 64'(n), 64'd32);
    wait_edges(1);
    check_frame("t2_neg");

    // Decimal boundaries.
    apply("t3_max_pos", 32'd99_999_999, 1'b1, 1'b1, 64'h6F6F_6F6F_6F6F_6F6F);
    apply("t3_ovf_pos", 32'd100_000_000, 1'b1, 1'b1, 64'h4040_4040_4040_4040);
    apply("t3_max_neg", -32'sd9_999_999, 1'b1, 1'b1, 64'h406F_6F6F_6F6F_6F6F);
    apply("t3_int_min", 32'h8000_0000, 1'b1, 1'b1, 64'h4040_4040_4040_4040);

    // Zero with blanking in both modes, then a blank-only change re-triggers.
    apply("t4_zero_hex", 32'd0, 1'b0, 1'b1, 64'h0000_0000_0000_003F);
    apply("t4_zero_dec", 32'd0, 1'b1, 1'b1, 64'h0000_0000_0000_003F);
    apply("t7_blank_off", 32'd0, 1'b1, 1'b0, 64'h3F3F_3F3F_3F3F_3F3F);

    // Input change 10 cycles into CONV is deferred until after the commit.
    drive(32'd12_345_678, 1'b1, 1'b0, 64'h065B_4F66_6D7D_077F);
    wait_edges(11);
    bus_if.value_i = -32'sd42;
    exp_q.push_back(64'h403F_3F3F_3F3F_665B);
    wait_edges(23);
    check_frame("t5_first");
    check("t5_busy_second", 64'(bus_if.busy_o), 64'd1);
    wait_busy(n);
    wait_edges(1);
    check_frame("t5_second");

    // Reset mid-conversion and mid-scan, then redisplay from scratch.
    frame7 = 64'h0000_0000_0000_0007;
    drive(32'd7, 1'b1, 1'b1, frame7);
    wait_edges(11);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_seg", 64'(bus_if.seg_o), 64'd0);
    check("t6_rst_an", 64'(bus_if.an_o), 64'd0);
    check("t6_rst_busy", 64'(bus_if.busy_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_edges(1);
    check("t6_an_pre", 64'(bus_if.an_o), 64'd0);
    wait_busy(n);
    wait_edges(1);
    edges = n + 2;
    check("t6_an_idx", 64'(bus_if.an_o), 64'(8'd1 << ((edges / SCAN_DIV) % 8)));
    check("t6_seg_first", 64'(bus_if.seg_o), 64'(frame7[8*((edges / SCAN_DIV) % 8) +: 8]));
    check_frame("t6_redisplay");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
